// File: rtl/issue_scheduler_pkg.sv
// Shared field widths, constants and types for the instruction issue scheduler.
package issue_scheduler_pkg;

   localparam int OPC_W  = 5;
   localparam int REG_W  = 4;
   localparam int DATA_W = 32;

   localparam logic [OPC_W-1:0] NOP_OPC = '0;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } sched_state_t;

   typedef struct packed {
      logic [OPC_W-1:0]  opcode;
      logic [REG_W-1:0]  s1;
      logic [REG_W-1:0]  s2;
      logic [REG_W-1:0]  dest;
      logic [DATA_W-1:0] imm;
   } instr_t;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dest;
   } sb_slot_t;

endpackage

// File: rtl/issue_scheduler_instr_fifo.sv
// Synchronous FIFO with clear; a push while full is refused even when a pop
// happens in the same cycle.
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     sys_clk,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = 1;
   localparam logic [PTR_W:0]   CNT_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (do_push && !clear) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/issue_scheduler.sv
// Issue controller: queues instructions, holds back RAW hazards against a
// write-back scoreboard, and drains the pipeline on a flush request.
//
// state | meaning
// RUN   | normal accept and issue
// DRAIN | queue cleared, bubbles only until scoreboard empties
// DONE  | drain complete, flush_done pulses next cycle, back to RUN
module issue_scheduler
   import issue_scheduler_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int WB_LAT = 3
) (
   input  logic                    sys_clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [OPC_W-1:0]        opcode_in,
   input  logic [REG_W-1:0]        s1_in,
   input  logic [REG_W-1:0]        s2_in,
   input  logic [REG_W-1:0]        dest_in,
   input  logic [DATA_W-1:0]       ime_data_in,
   output logic [OPC_W-1:0]        opcode_out,
   output logic [REG_W-1:0]        s1_out,
   output logic [REG_W-1:0]        s2_out,
   output logic [REG_W-1:0]        dest_out,
   output logic [DATA_W-1:0]       ime_data_out,
   output logic                    issue_valid,
   output logic                    stall,
   input  logic                    flush_req,
   output logic                    flush_done,
   output logic [$clog2(DEPTH):0]  q_count
);

   sched_state_t state, state_nxt;
   sb_slot_t     sb [WB_LAT];
   instr_t       head;
   instr_t       in_instr;
   instr_t       out_q;
   logic         fifo_full;
   logic         fifo_empty;
   logic         is_run;
   logic         hazard;
   logic         sb_busy;
   logic         do_push;
   logic         do_issue;
   logic         flush_clear;

   assign in_instr = '{opcode: opcode_in, s1: s1_in, s2: s2_in,
                       dest: dest_in, imm: ime_data_in};

   assign is_run      = (state == ST_RUN);
   assign in_ready    = !fifo_full && is_run;
   assign flush_clear = is_run && flush_req;
   assign do_push     = in_valid && in_ready && !flush_req;
   assign do_issue    = is_run && !flush_req && !fifo_empty && !hazard;
   assign stall       = is_run && !fifo_empty && hazard;

   instr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(instr_t))
   ) u_fifo (
      .sys_clk (sys_clk),
      .reset_n (reset_n),
      .clear   (flush_clear),
      .push    (do_push),
      .pop     (do_issue),
      .wdata   (in_instr),
      .rdata   (head),
      .count   (q_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      hazard  = 1'b0;
      sb_busy = 1'b0;
      for (int i = 0; i < WB_LAT; i++) begin
         if (sb[i].valid) begin
            sb_busy = 1'b1;
            if (head.s1 == sb[i].dest || head.s2 == sb[i].dest) hazard = 1'b1;
         end
      end
      if (head.opcode == NOP_OPC) hazard = 1'b0;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:   if (flush_req) state_nxt = ST_DRAIN;
         ST_DRAIN: if (!sb_busy) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) state <= ST_RUN;
      else          state <= state_nxt;
   end

   // Write-back shadow: a slot stays valid until its result is in the register file.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < WB_LAT; i++) sb[i] <= '0;
      end else begin
         sb[0].valid <= do_issue && (head.opcode != NOP_OPC);
         sb[0].dest  <= head.dest;
         for (int i = 1; i < WB_LAT; i++) sb[i] <= sb[i-1];
      end
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q       <= '0;
         issue_valid <= 1'b0;
         flush_done  <= 1'b0;
      end else begin
         out_q       <= do_issue ? head : '0;
         issue_valid <= do_issue;
         flush_done  <= (state == ST_DONE);
      end
   end

   assign opcode_out   = out_q.opcode;
   assign s1_out       = out_q.s1;
   assign s2_out       = out_q.s2;
   assign dest_out     = out_q.dest;
   assign ime_data_out = out_q.imm;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: reset, independent issue, RAW stall,
// full queue, flush drain and NOP handling.
module tb_issue_scheduler;

   logic        sys_clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  opcode_in;
   logic [3:0]  s1_in, s2_in, dest_in;
   logic [31:0] ime_data_in;
   logic [4:0]  opcode_out;
   logic [3:0]  s1_out, s2_out, dest_out;
   logic [31:0] ime_data_out;
   logic        issue_valid;
   logic        stall;
   logic        flush_req;
   logic        flush_done;
   logic [2:0]  q_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 sys_clk = ~sys_clk;

   issue_scheduler #(.DEPTH(4), .WB_LAT(3)) dut (
      .sys_clk      (sys_clk),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .opcode_in    (opcode_in),
      .s1_in        (s1_in),
      .s2_in        (s2_in),
      .dest_in      (dest_in),
      .ime_data_in  (ime_data_in),
      .opcode_out   (opcode_out),
      .s1_out       (s1_out),
      .s2_out       (s2_out),
      .dest_out     (dest_out),
      .ime_data_out (ime_data_out),
      .issue_valid  (issue_valid),
      .stall        (stall),
      .flush_req    (flush_req),
      .flush_done   (flush_done),
      .q_count      (q_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic push_instr(input logic [4:0] opc, input logic [3:0] d,
                             input logic [3:0] s1, input logic [3:0] s2,
                             input logic [31:0] imm);
      in_valid    = 1'b1;
      opcode_in   = opc;
      dest_in     = d;
      s1_in       = s1;
      s2_in       = s2;
      ime_data_in = imm;
   endtask

   task automatic idle();
      in_valid    = 1'b0;
      opcode_in   = '0;
      dest_in     = '0;
      s1_in       = '0;
      s2_in       = '0;
      ime_data_in = '0;
   endtask

   initial begin
      reset_n   = 1'b0;
      flush_req = 1'b0;
      idle();
      step();
      step();
      chk("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
      chk("rst_opcode", {27'd0, opcode_out}, 32'd0);
      chk("rst_imm", ime_data_out, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_q_count", {29'd0, q_count}, 32'd0);
      chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
      reset_n = 1'b1;
      step();

      // independent stream
      push_instr(5'd1, 4'd1, 4'd2, 4'd3, 32'h11);
      step();
      chk("ind_q1", {29'd0, q_count}, 32'd1);
      chk("ind_not_yet", {31'd0, issue_valid}, 32'd0);
      push_instr(5'd2, 4'd4, 4'd5, 4'd6, 32'h22);
      step();
      chk("ind_a_opc", {27'd0, opcode_out}, 32'd1);
      chk("ind_a_valid", {31'd0, issue_valid}, 32'd1);
      chk("ind_a_fields", {16'd0, s1_out, s2_out, dest_out, 4'd0}, 32'h2310);
      chk("ind_a_imm", ime_data_out, 32'h11);
      chk("ind_a_stall", {31'd0, stall}, 32'd0);
      idle();
      step();
      chk("ind_b_opc", {27'd0, opcode_out}, 32'd2);
      chk("ind_b_dest", {28'd0, dest_out}, 32'd4);
      chk("ind_b_valid", {31'd0, issue_valid}, 32'd1);
      chk("ind_b_stall", {31'd0, stall}, 32'd0);
      chk("ind_b_q", {29'd0, q_count}, 32'd0);
      step();
      chk("ind_bubble_valid", {31'd0, issue_valid}, 32'd0);
      chk("ind_bubble_opc", {27'd0, opcode_out}, 32'd0);
      repeat (3) step();

      // RAW hazard: consumer issues 4 cycles after producer
      push_instr(5'd3, 4'd1, 4'd2, 4'd3, 32'h5);
      step();
      push_instr(5'd4, 4'd5, 4'd1, 4'd4, 32'h6);
      step();
      chk("raw_prod_opc", {27'd0, opcode_out}, 32'd3);
      chk("raw_stall_c0", {31'd0, stall}, 32'd1);
      idle();
      step();
      chk("raw_bubble1", {31'd0, issue_valid}, 32'd0);
      chk("raw_stall_c1", {31'd0, stall}, 32'd1);
      step();
      chk("raw_bubble2", {31'd0, issue_valid}, 32'd0);
      chk("raw_stall_c2", {31'd0, stall}, 32'd1);
      step();
      chk("raw_bubble3", {31'd0, issue_valid}, 32'd0);
      chk("raw_stall_c3", {31'd0, stall}, 32'd0);
      step();
      chk("raw_cons_opc", {27'd0, opcode_out}, 32'd4);
      chk("raw_cons_valid", {31'd0, issue_valid}, 32'd1);
      chk("raw_cons_s1", {28'd0, s1_out}, 32'd1);
      repeat (4) step();

      // full FIFO behind a hazard
      push_instr(5'd5, 4'd1, 4'd2, 4'd3, 32'h50);
      step();
      push_instr(5'd6, 4'd5, 4'd1, 4'd4, 32'h60);
      step();
      chk("full_q1", {29'd0, q_count}, 32'd1);
      push_instr(5'd7, 4'd6, 4'd2, 4'd3, 32'h70);
      step();
      chk("full_q2", {29'd0, q_count}, 32'd2);
      push_instr(5'd8, 4'd7, 4'd2, 4'd3, 32'h80);
      step();
      chk("full_q3", {29'd0, q_count}, 32'd3);
      chk("full_stall", {31'd0, stall}, 32'd1);
      push_instr(5'd9, 4'd8, 4'd2, 4'd3, 32'h90);
      step();
      chk("full_q4", {29'd0, q_count}, 32'd4);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      push_instr(5'd10, 4'd9, 4'd2, 4'd3, 32'hA0);
      step();
      chk("full_pop_opc", {27'd0, opcode_out}, 32'd6);
      chk("full_refused_q", {29'd0, q_count}, 32'd3);
      chk("full_ready_again", {31'd0, in_ready}, 32'd1);
      idle();
      step();
      chk("full_c_opc", {27'd0, opcode_out}, 32'd7);
      chk("full_c_imm", ime_data_out, 32'h70);
      step();
      chk("full_d_opc", {27'd0, opcode_out}, 32'd8);
      step();
      chk("full_e_opc", {27'd0, opcode_out}, 32'd9);
      chk("full_e_q", {29'd0, q_count}, 32'd0);
      step();
      chk("full_no_f", {31'd0, issue_valid}, 32'd0);
      repeat (4) step();

      // flush with 2 queued and 1 in flight
      push_instr(5'd11, 4'd1, 4'd2, 4'd3, 32'hB0);
      step();
      push_instr(5'd12, 4'd5, 4'd1, 4'd4, 32'hC0);
      step();
      chk("fl_x_opc", {27'd0, opcode_out}, 32'd11);
      push_instr(5'd13, 4'd6, 4'd2, 4'd3, 32'hD0);
      step();
      chk("fl_q2", {29'd0, q_count}, 32'd2);
      push_instr(5'd14, 4'd7, 4'd2, 4'd3, 32'hE0);
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      idle();
      chk("fl_cleared", {29'd0, q_count}, 32'd0);
      chk("fl_ready_drain", {31'd0, in_ready}, 32'd0);
      chk("fl_bubble", {31'd0, issue_valid}, 32'd0);
      chk("fl_done_e4", {31'd0, flush_done}, 32'd0);
      flush_req = 1'b1;
      push_instr(5'd14, 4'd7, 4'd2, 4'd3, 32'hE0);
      step();
      flush_req = 1'b0;
      idle();
      chk("fl_done_e5", {31'd0, flush_done}, 32'd0);
      chk("fl_q_e5", {29'd0, q_count}, 32'd0);
      step();
      chk("fl_done_e6", {31'd0, flush_done}, 32'd0);
      chk("fl_ready_e6", {31'd0, in_ready}, 32'd0);
      step();
      chk("fl_done_e7", {31'd0, flush_done}, 32'd1);
      chk("fl_ready_e7", {31'd0, in_ready}, 32'd1);
      push_instr(5'd15, 4'd2, 4'd3, 4'd4, 32'hF0);
      step();
      idle();
      chk("fl_done_e8", {31'd0, flush_done}, 32'd0);
      chk("fl_reaccept_q", {29'd0, q_count}, 32'd1);
      chk("fl_no_stale", {31'd0, issue_valid}, 32'd0);
      step();
      chk("fl_v_opc", {27'd0, opcode_out}, 32'd15);
      repeat (4) step();

      // flush with empty scoreboard: flush_done 2 cycles after sampling edge
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      chk("fl2_done_f1", {31'd0, flush_done}, 32'd0);
      step();
      chk("fl2_done_f2", {31'd0, flush_done}, 32'd0);
      step();
      chk("fl2_done_f3", {31'd0, flush_done}, 32'd1);
      step();
      chk("fl2_done_f4", {31'd0, flush_done}, 32'd0);

      // NOP writing r7 does not block a reader of r7
      push_instr(5'd0, 4'd7, 4'd0, 4'd0, 32'h0);
      step();
      push_instr(5'd16, 4'd8, 4'd7, 4'd7, 32'h77);
      step();
      idle();
      chk("nop_issued", {31'd0, issue_valid}, 32'd1);
      chk("nop_dest", {28'd0, dest_out}, 32'd7);
      chk("nop_no_stall", {31'd0, stall}, 32'd0);
      step();
      chk("nop_reader_opc", {27'd0, opcode_out}, 32'd16);
      chk("nop_reader_valid", {31'd0, issue_valid}, 32'd1);

      // reset mid-stream with 3 queued
      push_instr(5'd17, 4'd1, 4'd2, 4'd3, 32'h170);
      step();
      push_instr(5'd18, 4'd2, 4'd1, 4'd1, 32'h180);
      step();
      push_instr(5'd19, 4'd3, 4'd1, 4'd1, 32'h190);
      step();
      push_instr(5'd20, 4'd4, 4'd1, 4'd1, 32'h1A0);
      step();
      idle();
      chk("mr_q3", {29'd0, q_count}, 32'd3);
      chk("mr_stall", {31'd0, stall}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mr_q0", {29'd0, q_count}, 32'd0);
      chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
      chk("mr_stall0", {31'd0, stall}, 32'd0);
      chk("mr_valid0", {31'd0, issue_valid}, 32'd0);
      step();
      reset_n = 1'b1;
      repeat (3) begin
         step();
         chk("mr_no_issue", {31'd0, issue_valid}, 32'd0);
      end
      chk("mr_q_after", {29'd0, q_count}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Instruction issue controller for the four-stage 32-bit pipeline (fetch, decode, register file, execute). It buffers incoming instructions in a small FIFO and issues at most one per clock into the fetch stage. A destination-register scoreboard holds an instruction back while it would read a register that an in-flight instruction has not yet written, and a NOP bubble is issued in its place. A flush request empties the queue and drains the pipeline.

## Interface
Parameters:
- `DEPTH`, 4: instruction FIFO entries (power of two, ≥2).
- `WB_LAT`, 3: cycles from issue until the execute stage has written the register file.

Ports:
- `sys_clk`, in, 1: the single clock; all state updates on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: an instruction is offered.
- `in_ready`, out, 1: the FIFO can accept an instruction.
- `opcode_in`, in, 5: opcode. `5'd0` is a NOP, which neither reads nor writes registers.
- `s1_in`, `s2_in`, `dest_in`, in, 4 each: source and destination register indices.
- `ime_data_in`, in, 32: immediate operand.
- `opcode_out`, `s1_out`, `s2_out`, `dest_out`, `ime_data_out`, out, 5/4/4/4/32: issued instruction, driven to the fetch stage.
- `issue_valid`, out, 1: the output holds a real instruction, not a bubble.
- `stall`, out, 1: the head instruction is blocked by a hazard this cycle.
- `flush_req`, in, 1: single-cycle pulse requesting a flush.
- `flush_done`, out, 1: single-cycle pulse when the drain has completed.
- `q_count`, out, $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
**Reset.**
- All outputs are 0, except `in_ready`, which is 1.
- FIFO is empty, scoreboard is cleared, FSM is in RUN.
- Reset asserted mid-operation discards all queued and in-flight state immediately.

**Accept.**
- `in_ready` = (`q_count` < `DEPTH`) && state == RUN.
- An instruction is pushed when `in_valid` && `in_ready`.
- When the FIFO is full, a push is refused even if a pop happens in the same cycle; there is no bypass.

**Hazard.**
- The head instruction is blocked if it is not a NOP and `s1` or `s2` equals the `dest` of any valid scoreboard slot.
- Register index 0 is not special.

**Issue.**
- In RUN, when the FIFO is non-empty and there is no hazard, the head is popped and registered onto the outputs with `issue_valid` = 1.
- Otherwise the outputs are set to a bubble: every field 0 and `issue_valid` = 0.
- `stall` = RUN && non-empty && hazard.

**Scoreboard.**
- Shift register `sb[0..WB_LAT-1]`, each slot holding `{valid, dest}`.
- Every cycle it shifts by one; `sb[0]` loads `{issued && opcode != 0, dest}`.
- The slot leaving `sb[WB_LAT-1]` retires.

**FSM.**
- States: RUN, DRAIN, DONE.
- RUN → DRAIN when `flush_req` is seen. In that cycle the FIFO is cleared, no issue happens, and a push in the same cycle is dropped.
- DRAIN: bubbles only. DRAIN → DONE once no scoreboard slot is valid.
- DONE: `flush_done` = 1 for one cycle, then → RUN.
- `flush_req` is ignored while in DRAIN or DONE.

## Timing
- Push at edge N into an empty FIFO with no hazard: instruction appears on the outputs after edge N+1 (2-cycle latency).
- Back-to-back independent instructions issue one per cycle.
- Dependent instruction (its `s1`/`s2` equals the previous `dest`): it waits `WB_LAT` bubble cycles, then issues `WB_LAT`+1 cycles after its producer.
- Flush with an empty scoreboard: `flush_done` goes high 2 cycles after the edge that sampled `flush_req`.
- `q_count`, `in_ready` and `stall` reflect the registered state of the current cycle.

## Structure
- Shared package holds:
  - field widths: `OPC_W` = 5, `REG_W` = 4, `DATA_W` = 32;
  - the `NOP_OPC` constant;
  - the FSM state enum.
- One natural sub-module, `instr_fifo`: synchronous FIFO with parameterised depth and width. It exposes push/pop/clear/count; pointers wrap modulo `DEPTH`.
- Scoreboard, hazard compare and FSM stay in `issue_scheduler`.

## Test plan
- **Reset:** assert `reset_n` low mid-stream with 3 instructions queued → all outputs 0, `q_count` = 0, `in_ready` = 1; no issue after release until a new push.
- **Independent stream:** push ADD r1←r2,r3 then SUB r4←r5,r6 on consecutive cycles → both issue on consecutive cycles with `issue_valid` = 1 and `stall` = 0.
- **RAW hazard:** push r1←r2,r3 then r5←r1,r4 → three bubbles with `stall` = 1; the consumer issues exactly 4 cycles after its producer.
- **Full FIFO:** hold the head with a hazard and push 5 instructions → `q_count` saturates at 4, `in_ready` = 0, the 5th push is refused, no overwrite; a pop in the same cycle as a push attempt while full still refuses the push.
- **Flush:** `flush_req` with 2 queued and 1 in flight → FIFO cleared, bubbles only, `flush_done` pulses once after the in-flight slot retires, then the block accepts again.
- **NOP handling:** a NOP whose `dest` = 7 is followed by a reader of r7 → no stall.
